// File: rtl/uart_pkg.sv
// Shared UART types and constants for the transmit arbiter and the baud generator.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      BUSY  = 2'd2
   } state_t;

   localparam int UART_DATA_W     = 8;
   localparam int FRAME_BITS      = 10;
   localparam int DEFAULT_CLK_DIV = 868;  // 100 MHz / 115200 baud

   // One frame plus two bit-times of slack before a stuck transmitter is abandoned.
   function automatic int frame_timeout(input int clk_div);
      return (FRAME_BITS + 2) * clk_div;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running baud enable: one-clk pulse every CLK_DIV cycles, shared by the TX and RX paths.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
   input  logic clk,
   input  logic reset_n,
   output logic baud_tick
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] PRE  = CW'(CLK_DIV - 2);

   logic [CW-1:0] r_cnt;
   logic          r_tick;

   // The tick is registered one count early so it is high exactly while the count sits at LAST.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else begin
         r_cnt  <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
         r_tick <= (r_cnt == PRE);
      end
   end

   assign baud_tick = r_tick;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte producers,
// with start/done sequencing, a BUSY timeout and the transmitter's baud enable.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int CLK_DIV     = DEFAULT_CLK_DIV,
   parameter int TIMEOUT_CYC = frame_timeout(CLK_DIV),
   parameter int IDW         = $clog2(NUM_REQ)
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]             req_ack,
   output logic                           tx_start,
   output logic [UART_DATA_W-1:0]         tx_data,
   output logic                           baud_tick,
   input  logic                           tx_done,
   output logic                           busy,
   output logic [IDW-1:0]                 grant_id,
   output logic                           timeout_err
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   state_t                 r_state;
   logic [NUM_REQ-1:0]     r_ack;
   logic                   r_tx_start;
   logic [UART_DATA_W-1:0] r_tx_data;
   logic                   r_busy;
   logic [IDW-1:0]         r_grant_id;
   logic                   r_timeout_err;
   logic                   r_tx_done_q;
   logic [TW-1:0]          r_tmo_cnt;

   logic [IDW-1:0]         w_winner;
   logic [UART_DATA_W-1:0] w_win_data;
   logic                   w_done;
   logic                   w_tmo_hit;

   // First valid index after the last grant, wrapping; returns last when nothing is valid.
   function automatic logic [IDW-1:0] rr_pick(input logic [IDW-1:0] last,
                                              input logic [NUM_REQ-1:0] valid);
      logic [IDW:0]   sum;
      logic [IDW-1:0] idx;
      logic           found;
      rr_pick = last;
      found   = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         sum = {1'b0, last} + (IDW+1)'(k);
         if (sum >= (IDW+1)'(NUM_REQ))
            sum = sum - (IDW+1)'(NUM_REQ);
         idx = sum[IDW-1:0];
         if (!found && valid[idx]) begin
            rr_pick = idx;
            found   = 1'b1;
         end
      end
   endfunction

   assign w_winner   = rr_pick(r_grant_id, req_valid);
   assign w_win_data = req_data[int'(w_winner)*UART_DATA_W +: UART_DATA_W];
   assign w_done     = tx_done & ~r_tx_done_q;
   assign w_tmo_hit  = ({1'b0, r_tmo_cnt} + 1'b1) >= (TW+1)'(TIMEOUT_CYC);

   uart_baud_gen #(
      .CLK_DIV   (CLK_DIV)
   ) u_baud_gen (
      .clk       (clk),
      .reset_n   (reset_n),
      .baud_tick (baud_tick)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= IDLE;
         r_ack         <= '0;
         r_tx_start    <= 1'b0;
         r_tx_data     <= '0;
         r_busy        <= 1'b0;
         r_grant_id    <= IDW'(NUM_REQ - 1);
         r_timeout_err <= 1'b0;
         r_tx_done_q   <= 1'b0;
         r_tmo_cnt     <= '0;
      end else begin
         r_tx_done_q <= tx_done;
         r_ack       <= '0;
         r_tx_start  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (|req_valid) begin
                  r_tx_data  <= w_win_data;
                  r_grant_id <= w_winner;
                  r_ack      <= NUM_REQ'(1) << w_winner;
                  r_busy     <= 1'b1;
                  r_state    <= START;
               end
            end
            START: begin
               r_tx_start <= 1'b1;
               r_tmo_cnt  <= '0;
               r_state    <= BUSY;
            end
            BUSY: begin
               // A done edge wins over a timeout landing in the same cycle.
               if (w_done) begin
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end else if (w_tmo_hit) begin
                  r_timeout_err <= 1'b1;
                  r_busy        <= 1'b0;
                  r_state       <= IDLE;
               end else if (r_tmo_cnt != TW'(TIMEOUT_CYC)) begin
                  r_tmo_cnt <= r_tmo_cnt + 1'b1;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign req_ack     = r_ack;
   assign tx_start    = r_tx_start;
   assign tx_data     = r_tx_data;
   assign busy        = r_busy;
   assign grant_id    = r_grant_id;
   assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: behavioural UART TX model, directed scenarios
// and a randomized multi-requester run checked against a round-robin reference model.
module tb_uart_tx_arbiter;
   import uart_pkg::*;

   localparam int N   = 4;
   localparam int CD  = 4;
   localparam int TMO = 48;

   logic           clk = 1'b0;
   logic           reset_n = 1'b0;
   logic [N-1:0]   req_valid = '0;
   logic [8*N-1:0] req_data = '0;
   logic [N-1:0]   req_ack;
   logic           tx_start;
   logic [7:0]     tx_data;
   logic           baud_tick;
   logic           tx_done;
   logic           busy;
   logic [1:0]     grant_id;
   logic           timeout_err;

   logic           stub_mode = 1'b0;
   logic           stub_done = 1'b0;
   logic           m_done;
   logic [3:0]     m_bits;
   logic [9:0]     m_sh;
   bit             line_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   assign tx_done = stub_mode ? stub_done : m_done;

   uart_tx_arbiter #(
      .NUM_REQ     (N),
      .CLK_DIV     (CD),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ack     (req_ack),
      .tx_start    (tx_start),
      .tx_data     (tx_data),
      .baud_tick   (baud_tick),
      .tx_done     (tx_done),
      .busy        (busy),
      .grant_id    (grant_id),
      .timeout_err (timeout_err)
   );

   // Behavioural transmitter: frame bits go out on baud ticks, done raised one tick after stop.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_done <= 1'b0;
         m_bits <= '0;
         m_sh   <= '0;
      end else if (tx_start) begin
         m_done <= 1'b0;
         m_bits <= 4'd11;
         m_sh   <= {1'b1, tx_data, 1'b0};
      end else if (baud_tick && m_bits != 0) begin
         if (m_bits == 4'd1)
            m_done <= 1'b1;
         else
            line_q.push_back(m_sh[0]);
         m_sh   <= m_sh >> 1;
         m_bits <= m_bits - 4'd1;
      end
   end

   function automatic int rr_ref(input int last, input logic [N-1:0] v);
      for (int k = 1; k <= N; k++)
         if (v[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      tick();
      reset_n   = 1'b0;
      req_valid = '0;
      stub_done = 1'b0;
      repeat (3) tick();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      tick();
      reset_n = 1'b0;
      #1;
      n_checks++; if (req_ack !== 4'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0000", req_ack); end
      n_checks++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
      n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
      n_checks++; if (grant_id !== 2'(N-1)) begin n_fail++; $display("FAIL reset_grant_id: got %0d want %0d", grant_id, N-1); end
      n_checks++; if (baud_tick !== 1'b0) begin n_fail++; $display("FAIL reset_baud_tick: got %b want 0", baud_tick); end
      repeat (2) tick();
      reset_n = 1'b1;
      tick();
      n_checks++; if (busy !== 1'b0 || req_ack !== 4'b0) begin n_fail++; $display("FAIL reset_idle: got busy=%b ack=%b want 0/0000", busy, req_ack); end
   endtask

   task automatic test_single();
      logic [9:0] frame;
      int         cyc;
      frame = {1'b1, 8'hA5, 1'b0};
      line_q.delete();
      req_data[7:0] = 8'hA5;
      req_valid     = 4'b0001;
      tick();
      n_checks++; if (req_ack !== 4'b0001) begin n_fail++; $display("FAIL single_ack: got %b want 0001", req_ack); end
      n_checks++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL single_start_early: got %b want 0", tx_start); end
      n_checks++; if (tx_data !== 8'hA5) begin n_fail++; $display("FAIL single_tx_data: got %h want a5", tx_data); end
      n_checks++; if (grant_id !== 2'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL single_grant: got id=%0d busy=%b want 0/1", grant_id, busy); end
      req_valid = '0;
      tick();
      n_checks++; if (tx_start !== 1'b1 || req_ack !== 4'b0) begin n_fail++; $display("FAIL single_start: got start=%b ack=%b want 1/0000", tx_start, req_ack); end
      tick();
      n_checks++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL single_start_width: got %b want 0", tx_start); end
      cyc = 0;
      while (tx_done !== 1'b1 && cyc < 200) begin tick(); cyc++; end
      n_checks++; if (cyc >= 200) begin n_fail++; $display("FAIL single_done_wait: got no tx_done want done within 200 clk"); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_at_done: got %b want 1", busy); end
      tick();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_after_done: got %b want 0", busy); end
      n_checks++; if (line_q.size() != 10) begin n_fail++; $display("FAIL single_line_len: got %0d want 10", line_q.size()); end
      for (int i = 0; i < 10 && i < line_q.size(); i++) begin
         n_checks++; if (line_q[i] !== frame[i]) begin n_fail++; $display("FAIL single_line_bit%0d: got %b want %b", i, line_q[i], frame[i]); end
      end
      $display("single frame: req 0 data a5 line bits %0d", line_q.size());
   endtask

   task automatic test_all_four();
      int order[$];
      int starts, dones, cyc, idx;
      bit outstanding;
      do_reset();
      req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
      req_valid = 4'b1111;
      starts = 0; dones = 0; cyc = 0; outstanding = 0;
      while (dones < 4 && cyc < 1000) begin
         tick(); cyc++;
         if (outstanding && tx_done === 1'b1) begin outstanding = 0; dones++; end
         if (tx_start === 1'b1) begin
            starts++;
            n_checks++; if (outstanding) begin n_fail++; $display("FAIL four_overlap: got tx_start during frame want none"); end
            outstanding = 1;
         end
         if (req_ack !== 4'b0) begin
            n_checks++; if (!$onehot(req_ack)) begin n_fail++; $display("FAIL four_onehot: got %b want one-hot", req_ack); end
            idx = 0;
            for (int i = 0; i < N; i++) if (req_ack[i]) idx = i;
            n_checks++; if (tx_data !== 8'(8'h10 + idx)) begin n_fail++; $display("FAIL four_data: got %h want %h", tx_data, 8'(8'h10 + idx)); end
            order.push_back(idx);
            req_valid[idx] = 1'b0;
            $display("four frame: req %0d data %02h", idx, tx_data);
         end
      end
      repeat (5) tick();
      n_checks++; if (cyc >= 1000) begin n_fail++; $display("FAIL four_wait: got %0d done want 4 within 1000 clk", dones); end
      n_checks++; if (starts != 4 || order.size() != 4) begin n_fail++; $display("FAIL four_count: got starts=%0d grants=%0d want 4/4", starts, order.size()); end
      for (int i = 0; i < order.size(); i++) begin
         n_checks++; if (order[i] != i) begin n_fail++; $display("FAIL four_order%0d: got %0d want %0d", i, order[i], i); end
      end
   endtask

   task automatic test_rr_pointer();
      int want[3] = '{2, 1, 2};
      int got[$];
      int cyc;
      req_data[23:16] = 8'h22;
      req_data[15:8]  = 8'h21;
      req_valid       = 4'b0100;
      cyc = 0;
      while (got.size() < 3 && cyc < 1000) begin
         tick(); cyc++;
         if (req_ack !== 4'b0) begin
            got.push_back(int'(grant_id));
            $display("rr frame: req %0d data %02h", grant_id, tx_data);
            if (got.size() == 1) req_valid[1] = 1'b1;
            if (got.size() == 2) req_valid[1] = 1'b0;
         end
      end
      req_valid = '0;
      n_checks++; if (got.size() != 3) begin n_fail++; $display("FAIL rr_wait: got %0d grants want 3", got.size()); end
      for (int i = 0; i < got.size(); i++) begin
         n_checks++; if (got[i] != want[i]) begin n_fail++; $display("FAIL rr_grant%0d: got %0d want %0d", i, got[i], want[i]); end
      end
      cyc = 0;
      while (busy !== 1'b0 && cyc < 200) begin tick(); cyc++; end
   endtask

   task automatic test_baud();
      int first;
      first = -1;
      req_data[15:8] = 8'h77;
      req_valid      = 4'b0010;
      for (int n = 0; n < 64; n++) begin
         tick();
         if (req_ack !== 4'b0) req_valid = '0;
         if (first < 0) begin
            if (baud_tick === 1'b1) first = n;
         end else begin
            n_checks++;
            if (baud_tick !== (((n - first) % CD) == 0)) begin
               n_fail++; $display("FAIL baud_tick_c%0d: got %b want %b", n, baud_tick, ((n - first) % CD) == 0);
            end
         end
      end
      n_checks++; if (first < 0 || first >= CD) begin n_fail++; $display("FAIL baud_first: got %0d want 0..%0d", first, CD-1); end
      $display("baud check: first tick at sample %0d", first);
   endtask

   task automatic test_done_timeout_tie();
      do_reset();
      stub_mode = 1'b1;
      stub_done = 1'b0;
      req_data[7:0] = 8'h3C;
      req_valid     = 4'b0001;
      tick();
      n_checks++; if (req_ack !== 4'b0001) begin n_fail++; $display("FAIL tie_ack: got %b want 0001", req_ack); end
      req_valid = '0;
      repeat (48) tick();
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL tie_busy_before: got %b want 1", busy); end
      stub_done = 1'b1;
      tick();
      n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL tie_timeout_err: got %b want 0", timeout_err); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tie_busy_after: got %b want 0", busy); end
      $display("tie frame: done and timeout coincide");
   endtask

   task automatic test_timeout();
      int cyc;
      stub_done = 1'b0;
      tick();
      req_data[31:24] = 8'hE1;
      req_valid       = 4'b1000;
      tick();
      n_checks++; if (req_ack !== 4'b1000) begin n_fail++; $display("FAIL tmo_ack: got %b want 1000", req_ack); end
      req_valid = '0;
      repeat (48) tick();
      n_checks++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL tmo_early: got err=%b busy=%b want 0/1", timeout_err, busy); end
      tick();
      n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL tmo_err: got %b want 1", timeout_err); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tmo_idle: got busy %b want 0", busy); end
      stub_mode = 1'b0;
      req_data[7:0] = 8'h5A;
      req_valid     = 4'b0001;
      cyc = 0;
      do begin tick(); cyc++; end while (req_ack === 4'b0 && cyc < 20);
      n_checks++; if (req_ack !== 4'b0001 || tx_data !== 8'h5A) begin n_fail++; $display("FAIL tmo_next: got ack=%b data=%h want 0001/5a", req_ack, tx_data); end
      req_valid = '0;
      cyc = 0;
      while (busy !== 1'b0 && cyc < 200) begin tick(); cyc++; end
      n_checks++; if (busy !== 1'b0 || timeout_err !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got busy=%b err=%b want 0/1", busy, timeout_err); end
      $display("timeout frame: err set, next request served");
   endtask

   task automatic test_reset_midframe();
      int cyc;
      line_q.delete();
      req_data[7:0] = 8'hC3;
      req_valid     = 4'b0001;
      tick();
      req_valid = '0;
      cyc = 0;
      while (line_q.size() < 6 && cyc < 200) begin tick(); cyc++; end
      n_checks++; if (cyc >= 200) begin n_fail++; $display("FAIL mid_wait: got %0d bits want 6", line_q.size()); end
      #2 reset_n = 1'b0;
      #1;
      n_checks++; if (req_ack !== 4'b0 || tx_start !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_outputs: got ack=%b start=%b busy=%b want 0", req_ack, tx_start, busy); end
      n_checks++; if (tx_data !== 8'h00 || timeout_err !== 1'b0 || baud_tick !== 1'b0) begin n_fail++; $display("FAIL mid_data: got data=%h err=%b tick=%b want 00/0/0", tx_data, timeout_err, baud_tick); end
      n_checks++; if (grant_id !== 2'(N-1)) begin n_fail++; $display("FAIL mid_grant_id: got %0d want %0d", grant_id, N-1); end
      tick();
      reset_n = 1'b1;
      repeat (2) tick();
      n_checks++; if (req_ack !== 4'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_replay: got ack=%b busy=%b want 0000/0", req_ack, busy); end
      req_data[7:0]   = 8'h01;
      req_data[31:24] = 8'h08;
      req_valid       = 4'b1001;
      tick();
      n_checks++; if (req_ack !== 4'b0001 || grant_id !== 2'd0) begin n_fail++; $display("FAIL mid_first_winner: got ack=%b id=%0d want 0001/0", req_ack, grant_id); end
      req_valid = '0;
      cyc = 0;
      while (busy !== 1'b0 && cyc < 200) begin tick(); cyc++; end
      $display("reset mid-frame: req 0 first after release");
   endtask

   task automatic test_random_traffic();
      logic [N-1:0] vb, nv, exp_ack;
      logic [7:0]   db[N];
      bit           m_idle, td1, td2;
      int           m_ptr, win, frames, cyc;
      do_reset();
      vb = '0; m_idle = 1; m_ptr = N - 1; td1 = 0; td2 = 0;
      for (int i = 0; i < N; i++) db[i] = 8'h00;
      frames = 0; cyc = 0;
      while (frames < 25 && cyc < 5000) begin
         tick(); cyc++;
         exp_ack = '0;
         win     = -1;
         if (m_idle && vb != 0) begin
            win = rr_ref(m_ptr, vb);
            exp_ack[win] = 1'b1;
            m_ptr  = win;
            m_idle = 0;
         end else if (!m_idle && td1 && !td2) begin
            m_idle = 1;
         end
         n_checks++; if (req_ack !== exp_ack) begin n_fail++; $display("FAIL rand_ack_c%0d: got %b want %b", cyc, req_ack, exp_ack); end
         n_checks++; if (busy !== !m_idle) begin n_fail++; $display("FAIL rand_busy_c%0d: got %b want %b", cyc, busy, !m_idle); end
         if (win >= 0) begin
            frames++;
            n_checks++; if (tx_data !== db[win] || grant_id !== 2'(win)) begin n_fail++; $display("FAIL rand_data_c%0d: got id=%0d data=%h want %0d/%h", cyc, grant_id, tx_data, win, db[win]); end
            $display("rand frame %0d: req %0d data %02h", frames, win, db[win]);
         end
         nv = vb;
         for (int i = 0; i < N; i++) begin
            if (exp_ack[i]) begin
               nv[i] = 1'($urandom_range(0, 1));
               db[i] = 8'($urandom);
            end else if (vb[i]) begin
               if ($urandom_range(0, 15) == 0) nv[i] = 1'b0;
            end else if ($urandom_range(0, 7) == 0) begin
               nv[i] = 1'b1;
               db[i] = 8'($urandom);
            end
            req_data[8*i +: 8] = db[i];
         end
         vb        = nv;
         req_valid = nv;
         td2 = td1;
         td1 = tx_done;
      end
      req_valid = '0;
      n_checks++; if (frames < 25) begin n_fail++; $display("FAIL rand_progress: got %0d frames want 25", frames); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_all_four();
      test_rr_pointer();
      test_baud();
      test_done_timeout_tie();
      test_timeout();
      test_reset_midframe();
      test_random_traffic();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
